// File: rtl/hs32_fetch_if.sv
// hs32_fetch_if: memory read port and pipeline output port of the hs32 fetch unit.
// The master modport is the fetch unit; the slave modport is its environment
// (memory plus execution pipeline plus redirect source).
interface hs32_fetch_if;
  // Memory request/grant port
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  // Pipeline valid/ready port
  logic        valid_o;
  logic        ready_i;
  logic [31:0] op_o;
  logic        banksel_o;
  // Back-end redirect
  logic        redir_i;
  logic [31:0] redir_pc_i;
  logic        redir_bank_i;

  modport master (
    output mem_req_o, mem_addr_o, valid_o, op_o, banksel_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, ready_i,
           redir_i, redir_pc_i, redir_bank_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o, valid_o, op_o, banksel_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i, ready_i,
           redir_i, redir_pc_i, redir_bank_i
  );
endinterface

// File: rtl/hs32_fetch.sv
// hs32_fetch: sequential instruction fetch with prefetch FIFO and redirect flush.
// Build option HS32_FETCH_PREFETCH_EN: when defined, up to DEPTH words may be in
// flight or buffered; when undefined, a single word at a time is fetched.
module hs32_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic         clk,
  input  logic         reset,
  hs32_fetch_if.master bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      addr_q, addr_d;
  logic             req_q, req_d;
  logic             stale_q, stale_d;
  logic             bank_q, bank_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [32:0]      fifo_q [DEPTH];

  logic             grant_c, ret_c, push_c, pop_c, issue_ok_c;
  logic [SUM_W-1:0] credit_c;
  logic [31:0]      redir_pc_c;

  // Next-state: in-flight accounting, FIFO pointers, redirect flush, issue decision
  always_comb begin
    pc_d    = pc_q;
    addr_d  = addr_q;
    req_d   = req_q;
    stale_d = stale_q;
    bank_d  = bank_q;
    count_d = count_q;
    outst_d = outst_q;
    disc_d  = disc_q;
    rd_d    = rd_q;
    wr_d    = wr_q;

    redir_pc_c = {bus.redir_pc_i[31:2], 2'b00};
    grant_c    = req_q && bus.mem_gnt_i;
    ret_c      = bus.mem_rvalid_i && (outst_q != '0);
    push_c     = ret_c && (disc_q == '0) && !bus.redir_i;
    pop_c      = valid_q && bus.ready_i && !bus.redir_i;

    if (grant_c && !ret_c) begin
      outst_d = outst_q + CNT_W'(1);
    end else if (!grant_c && ret_c) begin
      outst_d = outst_q - CNT_W'(1);
    end

    if (ret_c && (disc_q != '0)) begin
      disc_d = disc_q - CNT_W'(1);
    end
    // A request left pending across a redirect belongs to the old stream.
    if (grant_c && stale_q) begin
      disc_d = disc_d + CNT_W'(1);
    end
    if (grant_c) begin
      stale_d = 1'b0;
    end

    if (push_c) begin
      wr_d = wr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_d = rd_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (bus.redir_i) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
      disc_d  = outst_d;
      bank_d  = bus.redir_bank_i;
      pc_d    = redir_pc_c;
      if (req_q && !grant_c) begin
        stale_d = 1'b1;
      end
    end

    credit_c = SUM_W'(count_d) + SUM_W'(outst_d);
`ifdef HS32_FETCH_PREFETCH_EN
    issue_ok_c = credit_c < SUM_W'(DEPTH);
`else
    issue_ok_c = credit_c == '0;
`endif

    // An ungranted request keeps its address; otherwise issue from pc if credit allows.
    if (req_q && !grant_c) begin
      req_d = 1'b1;
    end else begin
      req_d = issue_ok_c;
      if (issue_ok_c) begin
        addr_d = pc_d;
        pc_d   = pc_d + 32'd4;
      end
    end

    valid_d = count_d != '0;
  end

  // State registers and FIFO storage
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      req_q   <= 1'b0;
      stale_q <= 1'b0;
      bank_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
      outst_q <= '0;
      disc_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      stale_q <= stale_d;
      bank_q  <= bank_d;
      valid_q <= valid_d;
      count_q <= count_d;
      outst_q <= outst_d;
      disc_q  <= disc_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      if (push_c) begin
        fifo_q[wr_q] <= {bank_q, bus.mem_rdata_i};
      end
    end
  end

  assign bus.mem_req_o  = req_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.valid_o    = valid_q;
  assign bus.op_o       = fifo_q[rd_q][31:0];
  assign bus.banksel_o  = fifo_q[rd_q][32];

`ifndef SYNTHESIS
  // Memory must not return data that was never granted.
  always_ff @(posedge clk) begin
    if (!reset && bus.mem_rvalid_i) begin
      assert (outst_q != '0)
        else $error("hs32_fetch: read data returned with nothing outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_hs32_fetch.sv
// tb_hs32_fetch: directed, table-driven and random checks of hs32_fetch against
// a stream-level reference (expected address sequence per redirect).
module tb_hs32_fetch;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] XORK  = 32'hA5A5_0000;
`ifdef HS32_FETCH_PREFETCH_EN
  localparam int unsigned LIMIT = DEPTH;
  localparam int          SPAN8 = 7;
`else
  localparam int unsigned LIMIT = 1;
  localparam int          SPAN8 = 21;
`endif
  localparam int TGT = (LIMIT >= 3) ? 3 : int'(LIMIT);

  typedef struct {
    logic [31:0] pc;
    logic        bank;
    logic [31:0] op0;
    logic [31:0] op1;
  } redir_vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hs32_fetch_if bus ();
  hs32_fetch_if bus2 ();

  hs32_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  hs32_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 1;
  int n_grants = 0;
  int n_hs    = 0;

  logic [31:0] mq[$];
  int          mq_due[$];
  logic [31:0] d2q[$];
  logic [31:0] d2log[$];
  logic [31:0] gnt_log[$];
  logic [31:0] hs_ops[$];
  logic        hs_bank[$];
  int          hs_cyc[$];

  logic [31:0] exp_addr;
  logic        exp_bank;
  bit          prev_hold, prev_stall, prev_redir;
  logic [31:0] prev_addr, prev_op;
  logic        prev_bank;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: check, drive inputs for the coming edge, update models, advance.
  task automatic tick(input bit gnt, input bit rdy, input bit rd,
                      input logic [31:0] rpc, input bit rbank);
    logic [31:0] a;
    if (prev_hold) begin
      chk1("req_hold", bus.mem_req_o, 1'b1);
      chk("addr_hold", bus.mem_addr_o, prev_addr);
    end
    if (prev_stall) begin
      chk1("stall_valid", bus.valid_o, 1'b1);
      chk("stall_op", bus.op_o, prev_op);
      chk1("stall_bank", bus.banksel_o, prev_bank);
    end
    if (prev_redir) chk1("valid_after_redir", bus.valid_o, 1'b0);
    chk1("inflight_limit", (mq.size() <= int'(LIMIT)), 1'b1);

    bus.mem_gnt_i    = gnt;
    bus.ready_i      = rdy;
    bus.redir_i      = rd;
    bus.redir_pc_i   = rpc;
    bus.redir_bank_i = rbank;
    if (mq.size() > 0 && mq_due[0] <= cyc) begin
      a = mq.pop_front();
      void'(mq_due.pop_front());
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = a ^ XORK;
    end else begin
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = $urandom;
    end
    if (bus.mem_req_o && gnt) begin
      mq.push_back(bus.mem_addr_o);
      mq_due.push_back(cyc + lat);
      gnt_log.push_back(bus.mem_addr_o);
      n_grants++;
    end
    if (bus.valid_o && rdy && !rd) begin
      chk("op", bus.op_o, exp_addr ^ XORK);
      chk1("banksel", bus.banksel_o, exp_bank);
      hs_ops.push_back(bus.op_o);
      hs_bank.push_back(bus.banksel_o);
      hs_cyc.push_back(cyc);
      n_hs++;
      exp_addr = exp_addr + 32'd4;
    end
    if (rd) begin
      exp_addr = {rpc[31:2], 2'b00};
      exp_bank = rbank;
    end
    prev_hold  = bus.mem_req_o && !gnt;
    prev_addr  = bus.mem_addr_o;
    prev_stall = bus.valid_o && !rdy && !rd;
    prev_op    = bus.op_o;
    prev_bank  = bus.banksel_o;
    prev_redir = rd;

    bus2.mem_gnt_i = 1'b1;
    bus2.ready_i   = 1'b1;
    if (d2q.size() > 0) begin
      bus2.mem_rvalid_i = 1'b1;
      bus2.mem_rdata_i  = d2q.pop_front() ^ XORK;
    end else begin
      bus2.mem_rvalid_i = 1'b0;
      bus2.mem_rdata_i  = 32'h0;
    end
    if (bus2.mem_req_o) begin
      d2q.push_back(bus2.mem_addr_o);
      if (d2log.size() < 3) d2log.push_back(bus2.mem_addr_o);
    end

    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_until_hs(input int n, input int bound);
    int k = 0;
    while (hs_ops.size() < n && k < bound) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      k++;
    end
    chk1("hs_within_bound", (hs_ops.size() >= n), 1'b1);
  endtask

  task automatic clear_logs();
    hs_ops.delete();
    hs_bank.delete();
    hs_cyc.delete();
    gnt_log.delete();
  endtask

  initial begin
    redir_vec_t vecs [5];
    logic [31:0] a0;
    logic [31:0] d2exp [3];
    int k;

    vecs[0] = '{32'h0000_1003, 1'b1, 32'hA5A5_1000, 32'hA5A5_1004};
    vecs[1] = '{32'h0000_2002, 1'b0, 32'hA5A5_2000, 32'hA5A5_2004};
    vecs[2] = '{32'hFFFF_FFFD, 1'b1, 32'h5A5A_FFFC, 32'hA5A5_0000};
    vecs[3] = '{32'h8000_0000, 1'b0, 32'h25A5_0000, 32'h25A5_0004};
    vecs[4] = '{32'h1234_5679, 1'b1, 32'hB791_5678, 32'hB791_567C};
    d2exp[0] = 32'hFFFF_FFF8;
    d2exp[1] = 32'hFFFF_FFFC;
    d2exp[2] = 32'h0000_0000;

    reset = 1'b1;
    bus.mem_gnt_i = 1'b0;  bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = 32'h0;
    bus.ready_i = 1'b0;    bus.redir_i = 1'b0;      bus.redir_pc_i = 32'h0;
    bus.redir_bank_i = 1'b0;
    bus2.mem_gnt_i = 1'b0; bus2.mem_rvalid_i = 1'b0; bus2.mem_rdata_i = 32'h0;
    bus2.ready_i = 1'b0;   bus2.redir_i = 1'b0;     bus2.redir_pc_i = 32'h0;
    bus2.redir_bank_i = 1'b0;
    exp_addr = 32'h0; exp_bank = 1'b0;
    prev_hold = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0;
    prev_addr = 32'h0; prev_op = 32'h0; prev_bank = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk1("reset_req", bus.mem_req_o, 1'b0);
    chk1("reset_valid", bus.valid_o, 1'b0);
    chk("reset_op", bus.op_o, 32'h0);
    chk1("reset_banksel", bus.banksel_o, 1'b0);
    chk1("reset_req2", bus2.mem_req_o, 1'b0);
    reset = 1'b0;

    // Pipeline stalled: prefetch fills up and requests stop
    lat = 1;
    tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk1("first_req", bus.mem_req_o, 1'b1);
    chk("first_addr", bus.mem_addr_o, 32'h0);
    repeat (20) tick(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk1("stall_req_off", bus.mem_req_o, 1'b0);
    chk("stall_fill", 32'(n_grants - n_hs), 32'(LIMIT));
    chk1("stall_valid_hi", bus.valid_o, 1'b1);
    chk("stall_head", bus.op_o, 32'hA5A5_0000);

    // Release: in-order delivery and steady throughput
    clear_logs();
    run_until_hs(14, 200);
    if (hs_ops.size() >= 14) begin
      for (int i = 0; i < 14; i++) chk("stream_op", hs_ops[i], XORK + 32'(4 * i));
      chk("throughput_span", 32'(hs_cyc[13] - hs_cyc[6]), 32'(SPAN8));
    end

    // Redirect with requests in flight
    lat = 6;
    k = 0;
    while (mq.size() < TGT && k < 60) begin
      tick(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      k++;
    end
    chk1("reach_inflight", (mq.size() >= TGT), 1'b1);
    clear_logs();
    tick(1'b0, 1'b1, 1'b1, 32'h0000_1003, 1'b1);
    lat = 1;
    run_until_hs(2, 100);
    if (hs_ops.size() >= 2) begin
      chk("redir_op0", hs_ops[0], 32'hA5A5_1000);
      chk("redir_op1", hs_ops[1], 32'hA5A5_1004);
      chk1("redir_bank", hs_bank[0], 1'b1);
    end

    // Grant withheld for 5 cycles with a redirect in the middle
    lat = 2;
    k = 0;
    while (!bus.mem_req_o && k < 40) begin
      tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      k++;
    end
    chk1("req_pending", bus.mem_req_o, 1'b1);
    a0 = bus.mem_addr_o;
    clear_logs();
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 32'h0000_2000, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("gnt_stall_addr", bus.mem_addr_o, a0);
    run_until_hs(1, 100);
    if (gnt_log.size() >= 2) begin
      chk("stale_grant_addr", gnt_log[0], a0);
      chk("new_grant_addr", gnt_log[1], 32'h0000_2000);
    end else begin
      chk("grant_log_size", 32'(gnt_log.size()), 32'd2);
    end
    if (hs_ops.size() >= 1) begin
      chk("post_stall_op", hs_ops[0], 32'hA5A5_2000);
      chk1("post_stall_bank", hs_bank[0], 1'b0);
    end

    // Table of redirect targets, including alignment and address wrap
    for (int v = 0; v < 5; v++) begin
      lat = $urandom_range(1, 3);
      clear_logs();
      tick(1'b1, 1'b1, 1'b1, vecs[v].pc, vecs[v].bank);
      run_until_hs(2, 100);
      if (hs_ops.size() >= 2) begin
        chk("vec_op0", hs_ops[0], vecs[v].op0);
        chk("vec_op1", hs_ops[1], vecs[v].op1);
        chk1("vec_bank", hs_bank[0], vecs[v].bank);
      end
    end

    // Random grants, stalls and redirects against the stream model
    lat = $urandom_range(1, 4);
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 50) == 0,
           $urandom, 1'($urandom));
    end
    clear_logs();
    run_until_hs(3, 200);

`ifndef HS32_FETCH_PREFETCH_EN
    // Single-word fetch with memory latency 3: one word every 5 cycles
    lat = 3;
    clear_logs();
    run_until_hs(6, 200);
    if (hs_cyc.size() >= 6) chk("nopf_span", 32'(hs_cyc[5] - hs_cyc[1]), 32'd20);
`endif

    // Second instance: reset address near the top wraps to zero
    chk1("d2_three_grants", (d2log.size() >= 3), 1'b1);
    for (int i = 0; i < 3; i++) begin
      if (d2log.size() > i) chk("d2_addr", d2log[i], d2exp[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hs32_fetch.md
# hs32_fetch

Instruction fetch unit feeding the hs32 execution pipeline. It generates sequential word addresses, issues in-order read requests on a simple request/grant memory port, buffers returned words in a prefetch FIFO, and presents them to the pipeline input as `op_o`/`banksel_o` under a valid/ready handshake. It also accepts a redirect from the back end, which flushes buffered and in-flight words and restarts fetch at a new address and bank.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: fetch address after reset; bits [1:0] must be 0.
- `DEPTH`, default 4: prefetch FIFO entries; power of two, 2 to 16.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_req_o`  out  1  read request; held with a stable `mem_addr_o` until granted.
- `mem_addr_o`  out  32  word-aligned read address.
- `mem_gnt_i`  in  1  request accepted this cycle when `mem_req_o && mem_gnt_i`.
- `mem_rvalid_i`  in  1  read data valid; responses return in grant order, at least 1 cycle after grant.
- `mem_rdata_i`  in  32  read data.
- `valid_o`  out  1  `op_o` holds a valid instruction.
- `ready_i`  in  1  pipeline accepts the word when `valid_o && ready_i`.
- `op_o`  out  32  instruction word (FIFO head).
- `banksel_o`  out  1  register bank tag captured with the word.
- `redir_i`  in  1  one-cycle redirect strobe.
- `redir_pc_i`  in  32  new fetch address; bits [1:0] ignored (forced 0).
- `redir_bank_i`  in  1  new bank select applied to all subsequent words.

## Operation

- State: `pc` (next address to request), `bank`, FIFO (`DEPTH` × 33 bits: data + bank), `outstanding` (granted, not yet returned), `discard` (returns to drop).
- Issue rule: assert `mem_req_o` when `fifo_count + outstanding < DEPTH` and no redirect this cycle, or while holding an ungranted request. On grant: `pc <= pc + 4` (mod 2^32, wraps 32'hFFFF_FFFC -> 0), `outstanding++`.
- Return: on `mem_rvalid_i`, `outstanding--`. If `discard > 0`, drop the word and decrement `discard`; otherwise push `{bank, mem_rdata_i}`. The credit rule guarantees no overflow.
- Pop: on `valid_o && ready_i`. A simultaneous push and pop keeps the count unchanged.
- Redirect (takes priority over everything):
  - FIFO cleared.
  - `discard <= outstanding_next` (including a grant or return occurring in the same cycle).
  - `pc <= {redir_pc_i[31:2],2'b00}`; `bank <= redir_bank_i`.
  - A handshake in the redirect cycle is treated as completed by the consumer; fetch ignores it.
- An ungranted request pending at redirect stays asserted with its old address until granted, and its response is counted in `discard`.
- `mem_rvalid_i` with `outstanding == 0` is a protocol error: ignored; asserted in simulation.

## Timing

- Reset values:
  - `mem_req_o`, `valid_o`, `outstanding`, `discard`, and FIFO count are 0.
  - `pc = RESET_PC`; `bank`, `banksel_o`, and `op_o` are 0.
- First `mem_req_o` is asserted the cycle after `reset` deasserts.
- Latency from `mem_rvalid_i` (cycle N) to `valid_o` is cycle N+1; there is no combinational path from memory to `op_o`.
- After `redir_i` (cycle N):
  - `valid_o` is 0 at N+1.
  - The new-address request appears at N+1, or after the stale request is granted.
- Sustained throughput: 1 word/cycle when memory grants every cycle and `ready_i` is held high.
- `valid_o`, `op_o`, and `banksel_o` are stable while `valid_o && !ready_i`.
- Reset mid-operation discards all state; late `mem_rvalid_i` after reset is the memory's responsibility (it must be reset together).

## Configuration

- `HS32_FETCH_PREFETCH_EN`:
  - Defined: credit rule as above; up to `DEPTH` words in flight or buffered.
  - Undefined: the effective limit is 1. A new request is issued only when `outstanding == 0` and the FIFO is empty. Throughput is at most 1 word per (memory latency + 2) cycles; all other behaviour is identical.

## Test plan

- Reset release, memory grants immediately with 1-cycle latency returning `addr ^ 32'hA5A5_0000`, `ready_i=1` -> addresses 0,4,8,… and `op_o` sequence 32'hA5A5_0000, 32'hA5A5_0004, …; sustained 1 word/cycle (prefetch enabled).
- `ready_i=0` for 20 cycles -> exactly `DEPTH`=4 words buffered and granted; `mem_req_o` deasserts; `op_o` holds 32'hA5A5_0000; on release, words return in order with no loss.
- Redirect to 32'h0000_1003, bank 1, with 3 requests outstanding -> the 3 stale returns are dropped; next `op_o` is from address 32'h0000_1000 with `banksel_o=1`.
- `mem_gnt_i` held low for 5 cycles -> `mem_addr_o` stable; redirect during the stall -> old request still completes and is discarded; new address is issued after the grant.
- `RESET_PC=32'hFFFF_FFF8` -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Prefetch disabled, memory latency 3 -> never more than 1 outstanding; one word every 5 cycles.
